spi_register_bank: RTL
======================

Name: spi_register_bank

Overview:
- Transaction decoder and register file directly downstream of spi_memory_slave.
- Consumes the slave's byte events (command, address, write data) and serves read data back to it.
- Drives the slave's expect_addr / expect_read / expect_write / insert_dummy_cycles phase controls.
- Exposes the register file to camera control logic as a flat bus plus a write strobe.

Parameters:
- ADDR_WIDTH, 8, width of address byte and internal pointer
- DEPTH, 16, number of implemented registers (0..DEPTH-1); DEPTH <= 2**ADDR_WIDTH
- DUMMY_ON_READ, 1, value driven on insert_dummy_cycles for command 0x0B (fast read)
- ID_VALUE, 8'hA5, read-only value returned at address 2**ADDR_WIDTH-1

Ports:
- main_clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cs  in  1  SPI chip select, already synchronised to main_clock, low = active
- addr  in  ADDR_WIDTH  address byte from slave
- addr_valid  in  1  one-cycle pulse, addr valid
- write_data  in  8  data byte from slave (command or write payload)
- write_data_valid  in  1  one-cycle pulse, write_data valid
- read_data  out  8  byte presented to slave for shifting out
- read_data_request  in  1  one-cycle pulse, slave requests next byte
- read_data_captured  in  1  one-cycle pulse, slave latched read_data
- expect_addr  out  1  next byte is an address
- expect_read  out  1  transaction is a read data phase
- expect_write  out  1  transaction is a write data phase
- insert_dummy_cycles  out  1  slave inserts 8 dummy cycles before read data
- regs_flat  out  8*DEPTH  register contents, reg n at bits [8n+7:8n]
- reg_wr_strobe  out  1  one-cycle pulse on each register write
- reg_wr_addr  out  ADDR_WIDTH  address of the write
- cmd_error  out  1  sticky: unknown command seen; cleared by reset only

Behaviour:
- Reset values: all regs 0, read_data 0, all expect_* 0, insert_dummy_cycles 0, reg_wr_strobe 0, reg_wr_addr 0, cmd_error 0, ptr 0, state IDLE.
- States: IDLE, CMD, ADDR, WRITE, READ, IGNORE.
- Any state, cs==1: next state IDLE and all expect_*/insert_dummy_cycles 0 on that edge. cs==1 has priority over a same-cycle data pulse; the pulse is dropped.
- IDLE -> CMD when cs==0. In CMD, expect_addr=1.
- CMD on write_data_valid, by command byte:
  - 0x02 (write) or 0x03 (read): -> ADDR, insert_dummy_cycles 0.
  - 0x0B (fast read): -> ADDR, insert_dummy_cycles=DUMMY_ON_READ.
  - any other byte: -> IGNORE, cmd_error<=1, expect_addr<=0.
- Output latency: every expect_* / insert_dummy_cycles change is visible on the edge after the triggering pulse (1-cycle latency).
- ADDR on addr_valid: ptr<=addr, expect_addr<=0.
  - Write command -> WRITE, expect_write<=1.
  - Read command -> READ, expect_read<=1.
- WRITE on write_data_valid:
  - ptr<DEPTH: regs[ptr]<=write_data; reg_wr_strobe=1 for one cycle with reg_wr_addr=ptr.
  - Otherwise: write dropped, no strobe.
  - ptr<=ptr+1, wrapping 2**ADDR_WIDTH-1 -> 0.
- READ, read_data_request: read_data<=value(ptr) on the next edge.
  - value(ptr) = regs[ptr] if ptr<DEPTH; ID_VALUE if ptr==2**ADDR_WIDTH-1; else 8'h00.
- READ, read_data_captured: ptr<=ptr+1 with the same wrap.
- Request and captured in the same cycle: read_data uses the pre-increment ptr; the increment still applies.
- read_data holds its value between requests and across IDLE.
- IGNORE: all data pulses ignored until cs==1.
- Address register 2**ADDR_WIDTH-1 is read-only in all cases.
- Reset asserted mid-transaction: immediate return to reset values; a new transaction is required after release.

Test Plan:
- Write burst: cs=0, cmd 0x02, addr 0x03, data 0x11,0x22 -> regs[3]=0x11, regs[4]=0x22; two reg_wr_strobe pulses, reg_wr_addr 3 then 4; expect_write=1 until cs=1.
- Read with capture: preload regs[5]=0x5A, regs[6]=0xC3; cmd 0x03, addr 0x05, request/captured twice -> read_data 0x5A then 0xC3; insert_dummy_cycles=0.
- Fast read and ID: cmd 0x0B, addr 0xFF -> insert_dummy_cycles=1, expect_read=1; first read_data 0xA5; after captured, ptr wraps to 0 and next read returns regs[0].
- Unmapped and illegal: write addr 0x20 data 0x77 -> no strobe, regs unchanged, read back 0x00; cmd 0x9F -> cmd_error=1, expect_addr=0, later bytes ignored.
- Abort and priority: cs=1 in the same cycle as write_data_valid during WRITE -> no write, state IDLE, expect_write=0 next edge; reset pulse mid-READ -> all outputs at reset values immediately, regs cleared.

Source files
------------

// File: rtl/spi_register_bank_if.sv
// Byte-event and phase-control bus between spi_memory_slave and spi_register_bank.
// The master side is the SPI slave front-end; the slave side is the register bank.
interface spi_register_bank_if #(
  parameter int unsigned ADDR_WIDTH = 8
) ();
  logic                  cs;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_valid;
  logic [7:0]            write_data;
  logic                  write_data_valid;
  logic [7:0]            read_data;
  logic                  read_data_request;
  logic                  read_data_captured;
  logic                  expect_addr;
  logic                  expect_read;
  logic                  expect_write;
  logic                  insert_dummy_cycles;

  modport master (
    output cs, addr, addr_valid, write_data, write_data_valid,
    output read_data_request, read_data_captured,
    input  read_data, expect_addr, expect_read, expect_write, insert_dummy_cycles
  );

  modport slave (
    input  cs, addr, addr_valid, write_data, write_data_valid,
    input  read_data_request, read_data_captured,
    output read_data, expect_addr, expect_read, expect_write, insert_dummy_cycles
  );
endinterface

// File: rtl/spi_register_bank.sv
// Command decoder and register file behind spi_memory_slave: decodes write/read/fast-read,
// steers the slave's phase controls and exposes the registers as a flat bus.
module spi_register_bank #(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DEPTH         = 16,
  parameter bit          DUMMY_ON_READ = 1'b1,
  parameter logic [7:0]  ID_VALUE      = 8'hA5
) (
  input  logic                  main_clock,
  input  logic                  reset,
  spi_register_bank_if.slave    bus,
  output logic [8*DEPTH-1:0]    regs_flat,
  output logic                  reg_wr_strobe,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic                  cmd_error
);

  localparam int unsigned           IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DepthLim = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] IdAddr   = '1;
  localparam logic [7:0]            CmdWrite    = 8'h02;
  localparam logic [7:0]            CmdRead     = 8'h03;
  localparam logic [7:0]            CmdFastRead = 8'h0B;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StWrite,
    StRead,
    StIgnore
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  is_write_q;
  logic [7:0]            regs_q [DEPTH];
  logic [7:0]            read_data_q;
  logic                  expect_addr_q;
  logic                  expect_read_q;
  logic                  expect_write_q;
  logic                  dummy_q;
  logic                  wr_strobe_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  cmd_error_q;

  logic                  ptr_mapped;
  logic                  ptr_is_id;
  logic                  ptr_writable;
  logic [IdxW-1:0]       ptr_idx;
  logic [ADDR_WIDTH-1:0] ptr_next;
  logic [7:0]            read_value;

  assign ptr_mapped   = ({1'b0, ptr_q} < DepthLim);
  assign ptr_is_id    = (ptr_q == IdAddr);
  // The ID address stays read-only even when DEPTH covers the whole address space.
  assign ptr_writable = ptr_mapped && !ptr_is_id;
  assign ptr_idx      = ptr_q[IdxW-1:0];
  assign ptr_next     = ptr_q + ADDR_WIDTH'(1);

  always_comb begin
    read_value = 8'h00;
    if (ptr_is_id) begin
      read_value = ID_VALUE;
    end else if (ptr_mapped) begin
      read_value = regs_q[ptr_idx];
    end
  end

  always_ff @(posedge main_clock or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      ptr_q          <= '0;
      is_write_q     <= 1'b0;
      regs_q         <= '{default: '0};
      read_data_q    <= 8'h00;
      expect_addr_q  <= 1'b0;
      expect_read_q  <= 1'b0;
      expect_write_q <= 1'b0;
      dummy_q        <= 1'b0;
      wr_strobe_q    <= 1'b0;
      wr_addr_q      <= '0;
      cmd_error_q    <= 1'b0;
    end else begin
      wr_strobe_q <= 1'b0;
      // Deselect wins over any data pulse arriving in the same cycle.
      if (bus.cs) begin
        state_q        <= StIdle;
        expect_addr_q  <= 1'b0;
        expect_read_q  <= 1'b0;
        expect_write_q <= 1'b0;
        dummy_q        <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            state_q       <= StCmd;
            expect_addr_q <= 1'b1;
          end
          StCmd: begin
            if (bus.write_data_valid) begin
              case (bus.write_data)
                CmdWrite, CmdRead: begin
                  state_q    <= StAddr;
                  is_write_q <= (bus.write_data == CmdWrite);
                  dummy_q    <= 1'b0;
                end
                CmdFastRead: begin
                  state_q    <= StAddr;
                  is_write_q <= 1'b0;
                  dummy_q    <= DUMMY_ON_READ;
                end
                default: begin
                  state_q       <= StIgnore;
                  cmd_error_q   <= 1'b1;
                  expect_addr_q <= 1'b0;
                end
              endcase
            end
          end
          StAddr: begin
            if (bus.addr_valid) begin
              ptr_q         <= bus.addr;
              expect_addr_q <= 1'b0;
              if (is_write_q) begin
                state_q        <= StWrite;
                expect_write_q <= 1'b1;
              end else begin
                state_q       <= StRead;
                expect_read_q <= 1'b1;
              end
            end
          end
          StWrite: begin
            if (bus.write_data_valid) begin
              if (ptr_writable) begin
                regs_q[ptr_idx] <= bus.write_data;
                wr_strobe_q     <= 1'b1;
                wr_addr_q       <= ptr_q;
              end
              ptr_q <= ptr_next;
            end
          end
          StRead: begin
            // Request samples the pre-increment pointer when both pulses coincide.
            if (bus.read_data_request) begin
              read_data_q <= read_value;
            end
            if (bus.read_data_captured) begin
              ptr_q <= ptr_next;
            end
          end
          StIgnore: begin
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign regs_flat[8*i +: 8] = regs_q[i];
  end

  assign bus.read_data           = read_data_q;
  assign bus.expect_addr         = expect_addr_q;
  assign bus.expect_read         = expect_read_q;
  assign bus.expect_write        = expect_write_q;
  assign bus.insert_dummy_cycles = dummy_q;
  assign reg_wr_strobe           = wr_strobe_q;
  assign reg_wr_addr             = wr_addr_q;
  assign cmd_error               = cmd_error_q;

endmodule
